conv_sequencer: RTL and testbench

- Top-level sequencer for the 3x3 convolution datapath.
- Loads 9 kernel weights, then walks every valid 3x3 window of an IMG_W x IMG_H image one tap per cycle.
- Per tap it drives the one-hot tap select, the load strobes and the buffer addresses; it pulses out_valid per output pixel.
- Sits between the host start/done handshake and the PE array / accumulator.

---
 rtl/conv_sequencer.sv | 232 +++++++++++++++++++++++
 tb/tb_conv_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_sequencer.sv
// Control sequencer for the 3x3 convolution datapath: loads the kernel, then
// steps every valid window one tap per cycle and flags each finished pixel.
module conv_sequencer #(
  parameter int unsigned IMG_W  = 8,
  parameter int unsigned IMG_H  = 8,
  parameter int unsigned ADDR_W = $clog2(IMG_W * IMG_H),
  parameter int unsigned CW     = $clog2((IMG_W > IMG_H) ? IMG_W : IMG_H)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              skip_kload,
  input  logic              abort,
  input  logic              stall,
  output logic [8:0]        sel,
  output logic              k_load,
  output logic              d_load,
  output logic [3:0]        k_addr,
  output logic [ADDR_W-1:0] d_addr,
  output logic              acc_clr,
  output logic              out_valid,
  output logic [CW-1:0]     out_row,
  output logic [CW-1:0]     out_col,
  output logic              busy,
  output logic              done
);

  localparam int unsigned TAP_W = 4;
  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(8);
  localparam logic [CW-1:0]    LAST_COL = CW'(IMG_W - 3);
  localparam logic [CW-1:0]    LAST_ROW = CW'(IMG_H - 3);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    KLOAD = 2'd1,
    CONV  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [TAP_W-1:0]   tap_q, tap_d;
  logic [CW-1:0]      row_q, row_d;
  logic [CW-1:0]      col_q, col_d;
  logic               pix_d;

  // Output registers hold the decode of the state being entered.
  logic [8:0]         sel_q, sel_d;
  logic               k_load_q, k_load_d;
  logic               d_load_q, d_load_d;
  logic [3:0]         k_addr_q, k_addr_d;
  logic [ADDR_W-1:0]  d_addr_q, d_addr_d;
  logic               acc_clr_q, acc_clr_d;
  logic               out_valid_q, out_valid_d;
  logic [CW-1:0]      out_row_q, out_row_d;
  logic [CW-1:0]      out_col_q, out_col_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               active_d;
  logic [1:0]         tap_r, tap_c;
  logic [ADDR_W-1:0]  win_row;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      tap_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tap_d       = tap_q;
    row_d       = row_q;
    col_d       = col_q;
    pix_d       = 1'b0;
    active_d    = 1'b0;
    tap_r       = 2'd0;
    tap_c       = 2'd0;
    win_row     = '0;
    sel_d       = '0;
    k_load_d    = 1'b0;
    d_load_d    = 1'b0;
    k_addr_d    = '0;
    d_addr_d    = '0;
    acc_clr_d   = 1'b0;
    out_valid_d = 1'b0;
    out_row_d   = '0;
    out_col_d   = '0;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = skip_kload ? CONV : KLOAD;
          tap_d   = '0;
          row_d   = '0;
          col_d   = '0;
        end
      end
      KLOAD: begin
        if (abort) begin
          state_d = IDLE;
          tap_d   = '0;
          row_d   = '0;
          col_d   = '0;
        end else if (!stall) begin
          if (tap_q == LAST_TAP) begin
            state_d = CONV;
            tap_d   = '0;
            row_d   = '0;
            col_d   = '0;
          end else begin
            tap_d = tap_q + TAP_W'(1);
          end
        end
      end
      CONV: begin
        if (abort) begin
          state_d = IDLE;
          tap_d   = '0;
          row_d   = '0;
          col_d   = '0;
        end else if (!stall) begin
          if (tap_q == LAST_TAP) begin
            tap_d = '0;
            pix_d = 1'b1;
            if (col_q == LAST_COL) begin
              col_d = '0;
              if (row_q == LAST_ROW) begin
                row_d   = '0;
                state_d = DONE;
              end else begin
                row_d = row_q + CW'(1);
              end
            end else begin
              col_d = col_q + CW'(1);
            end
          end else begin
            tap_d = tap_q + TAP_W'(1);
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Window offset of the tap: row = tap/3, col = tap%3.
    case (tap_d)
      4'd0: begin tap_r = 2'd0; tap_c = 2'd0; end
      4'd1: begin tap_r = 2'd0; tap_c = 2'd1; end
      4'd2: begin tap_r = 2'd0; tap_c = 2'd2; end
      4'd3: begin tap_r = 2'd1; tap_c = 2'd0; end
      4'd4: begin tap_r = 2'd1; tap_c = 2'd1; end
      4'd5: begin tap_r = 2'd1; tap_c = 2'd2; end
      4'd6: begin tap_r = 2'd2; tap_c = 2'd0; end
      4'd7: begin tap_r = 2'd2; tap_c = 2'd1; end
      4'd8: begin tap_r = 2'd2; tap_c = 2'd2; end
      default: begin tap_r = 2'd0; tap_c = 2'd0; end
    endcase

    active_d = (state_d == KLOAD) || (state_d == CONV);
    busy_d   = active_d;
    done_d   = (state_d == DONE);
    k_load_d = (state_d == KLOAD);
    d_load_d = (state_d == CONV);
    if (active_d) begin
      sel_d    = 9'(1) << tap_d;
      k_addr_d = tap_d;
    end
    if (state_d == CONV) begin
      win_row   = ADDR_W'(row_d) + ADDR_W'(tap_r);
      d_addr_d  = win_row * ADDR_W'(IMG_W) + ADDR_W'(col_d) + ADDR_W'(tap_c);
      acc_clr_d = (tap_d == '0);
    end

    out_valid_d = pix_d;
    if (pix_d) begin
      out_row_d = row_q;
      out_col_d = col_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_q       <= '0;
      k_load_q    <= 1'b0;
      d_load_q    <= 1'b0;
      k_addr_q    <= '0;
      d_addr_q    <= '0;
      acc_clr_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      sel_q       <= sel_d;
      k_load_q    <= k_load_d;
      d_load_q    <= d_load_d;
      k_addr_q    <= k_addr_d;
      d_addr_q    <= d_addr_d;
      acc_clr_q   <= acc_clr_d;
      out_valid_q <= out_valid_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Stall gates the load strobes immediately so a not-ready source is never sampled.
  assign sel       = sel_q & {9{~stall}};
  assign k_load    = k_load_q & ~stall;
  assign d_load    = d_load_q & ~stall;
  assign acc_clr   = acc_clr_q & ~stall;
  assign k_addr    = k_addr_q;
  assign d_addr    = d_addr_q;
  assign out_valid = out_valid_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed bench for conv_sequencer: per-tap and per-pixel scoreboards fed at job start.
module tb_conv_sequencer;

  localparam int unsigned IMG_W  = 8;
  localparam int unsigned IMG_H  = 8;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned CW     = 3;

  logic clk = 1'b0;
  logic rst;
  logic start, skip_kload, abort, stall;
  logic [8:0]        sel;
  logic              k_load, d_load, acc_clr, out_valid, busy, done;
  logic [3:0]        k_addr;
  logic [ADDR_W-1:0] d_addr;
  logic [CW-1:0]     out_row, out_col;

  conv_sequencer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .skip_kload(skip_kload),
    .abort(abort), .stall(stall), .sel(sel), .k_load(k_load),
    .d_load(d_load), .k_addr(k_addr), .d_addr(d_addr), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_row(out_row), .out_col(out_col),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              k;
    logic [8:0]        sel;
    logic [3:0]        kaddr;
    logic [ADDR_W-1:0] daddr;
    logic              clr;
  } tap_t;

  typedef struct packed {
    logic [CW-1:0] r;
    logic [CW-1:0] c;
  } pix_t;

  tap_t tap_q[$];
  pix_t pix_q[$];

  int errors = 0;
  int checks = 0;
  int cyc, exp_done, exp_first, done_seen, busy_cnt, pix_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected tap stream and pixel order for one job, built from the address formula.
  task automatic push_job(input bit with_kload);
    tap_t e;
    pix_t p;
    if (with_kload) begin
      for (int t = 0; t < 9; t++) begin
        e.k = 1'b1; e.sel = 9'd1 << t; e.kaddr = 4'(t); e.daddr = '0; e.clr = 1'b0;
        tap_q.push_back(e);
      end
    end
    for (int r = 0; r <= int'(IMG_H) - 3; r++) begin
      for (int c = 0; c <= int'(IMG_W) - 3; c++) begin
        p.r = CW'(r); p.c = CW'(c);
        pix_q.push_back(p);
        for (int t = 0; t < 9; t++) begin
          e.k     = 1'b0;
          e.sel   = 9'd1 << t;
          e.kaddr = 4'(t);
          e.daddr = ADDR_W'((r + t / 3) * int'(IMG_W) + c + t % 3);
          e.clr   = (t == 0);
          tap_q.push_back(e);
        end
      end
    end
  endtask

  task automatic monitor();
    tap_t e;
    pix_t p;
    if (k_load || d_load) begin
      if (tap_q.size() == 0) begin
        check("tap_unexpected", 32'({k_load, d_load}), 32'(0));
      end else begin
        e = tap_q.pop_front();
        check("k_load", 32'(k_load), 32'(e.k));
        check("d_load", 32'(d_load), 32'(!e.k));
        check("sel", 32'(sel), 32'(e.sel));
        check("k_addr", 32'(k_addr), 32'(e.kaddr));
        check("acc_clr", 32'(acc_clr), 32'(e.clr));
        if (!e.k) check("d_addr", 32'(d_addr), 32'(e.daddr));
      end
    end
    if (stall && busy)
      check("stall_gate", 32'({sel, k_load, d_load, acc_clr}), 32'(0));
    if (out_valid) begin
      if (pix_cnt == 0) check("first_valid_cycle", 32'(cyc), 32'(exp_first));
      pix_cnt++;
      if (pix_q.size() == 0) begin
        check("valid_unexpected", 32'(out_valid), 32'(0));
      end else begin
        p = pix_q.pop_front();
        check("out_row", 32'(out_row), 32'(p.r));
        check("out_col", 32'(out_col), 32'(p.c));
      end
    end else begin
      check("coord_idle_zero", 32'({out_row, out_col}), 32'(0));
    end
    if (busy) busy_cnt++;
    if (done) begin
      done_seen++;
      check("done_cycle", 32'(cyc), 32'(exp_done));
      check("busy_at_done", 32'(busy), 32'(0));
      check("last_valid_with_done", 32'(out_valid), 32'(1));
    end
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_job(input bit skip, input int done_at);
    cyc = 0; done_seen = 0; busy_cnt = 0; pix_cnt = 0;
    exp_done  = done_at;
    exp_first = skip ? 10 : 19;
    push_job(!skip);
    start = 1'b1; skip_kload = skip;
    tick();
    start = 1'b0; skip_kload = 1'b0;
  endtask

  task automatic end_job(input string tag, input int busy_exp, input int pix_exp, input int done_exp);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(busy_exp));
    check({tag, "_pixels"}, 32'(pix_cnt), 32'(pix_exp));
    check({tag, "_done_count"}, 32'(done_seen), 32'(done_exp));
    check({tag, "_taps_left"}, 32'(tap_q.size()), 32'(0));
    check({tag, "_pix_left"}, 32'(pix_q.size()), 32'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, 32'({sel, k_load, d_load, k_addr, acc_clr, out_valid, busy, done}), 32'(0));
    check({tag, "_addr"}, 32'({d_addr, out_row, out_col}), 32'(0));
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; skip_kload = 1'b0; abort = 1'b0; stall = 1'b0;
    cyc = 0; exp_done = -1; exp_first = -1; done_seen = 0; busy_cnt = 0; pix_cnt = 0;
    #12;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) tick();

    // Full job with kernel load; a start pulse while busy must be ignored.
    begin_job(1'b0, 334);
    repeat (99) tick();
    start = 1'b1; skip_kload = 1'b1;
    tick();
    start = 1'b0; skip_kload = 1'b0;
    repeat (235) tick();
    end_job("full", 333, 36, 1);

    // Resident kernel, three stall cycles at pixel (1,1) tap 4.
    begin_job(1'b1, 328);
    repeat (67) tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("stall_hold_daddr", 32'(d_addr), 32'(18));
      check("stall_busy", 32'(busy), 32'(1));
      tick();
    end
    stall = 1'b0;
    repeat (259) tick();
    end_job("stall", 327, 36, 1);

    // Abort at pixel (2,3) tap 5.
    begin_job(1'b0, -1);
    repeat (149) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tap_q.delete();
    pix_q.delete();
    check("abort_idle_busy", 32'(busy), 32'(0));
    repeat (20) tick();
    end_job("abort", 150, 15, 0);

    begin_job(1'b0, 334);
    repeat (335) tick();
    end_job("after_abort", 333, 36, 1);

    // Asynchronous reset in the middle of a convolution.
    begin_job(1'b1, -1);
    repeat (40) tick();
    check("pre_reset_busy", 32'(busy), 32'(1));
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("async_reset");
    tap_q.delete();
    pix_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    busy_cnt = 0; pix_cnt = 0; done_seen = 0;
    repeat (10) tick();
    end_job("post_reset", 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
